// File: rtl/conv3x3_engine.sv
// conv3x3_engine: three-stage valid/ready 3x3 convolution with normalising shift, abs and clamp.
// Define CONV3X3_COEF_WR_EN to enable the runtime coefficient write port; otherwise the kernel is a fixed Laplacian.
module conv3x3_engine #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [9*DATA_W-1:0] i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic                o_in_ready,
  input  logic [SHIFT_W-1:0]  i_shift,
  input  logic                i_abs_mode,
  input  logic                i_coef_wr,
  input  logic [3:0]          i_coef_addr,
  input  logic [COEF_W-1:0]   i_coef_data,
  output logic [DATA_W-1:0]   o_convolved_data,
  output logic                o_convolved_data_valid,
  input  logic                i_out_ready
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  function automatic logic signed [COEF_W-1:0] default_coef(input int k);
    case (k)
      4:          return COEF_W'(4);
      1, 3, 5, 7: return COEF_W'(-1);
      default:    return '0;
    endcase
  endfunction

  logic signed [COEF_W-1:0] coef [9];

`ifdef CONV3X3_COEF_WR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 9; k++) coef[k] <= default_coef(k);
    end else if (i_coef_wr) begin
      for (int k = 0; k < 9; k++) begin
        if (i_coef_addr == 4'(k)) coef[k] <= i_coef_data;
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < 9; k++) coef[k] = default_coef(k);
  end

  logic unused_coef_port;
  assign unused_coef_port = ^{i_coef_wr, i_coef_addr, i_coef_data};
`endif

  logic en;
  assign en         = !o_convolved_data_valid || i_out_ready;
  assign o_in_ready = en;

  logic signed [PROD_W-1:0] mult [9];
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      mult[k] = PROD_W'($signed({1'b0, i_pixel_data[k*DATA_W +: DATA_W]})) * PROD_W'(coef[k]);
    end
  end

  logic                     s1_valid, s2_valid;
  logic signed [PROD_W-1:0] s1_prod [9];
  logic [SHIFT_W-1:0]       s1_shift, s2_shift;
  logic                     s1_abs, s2_abs;
  logic signed [ACC_W-1:0]  s2_sum;

  logic signed [ACC_W-1:0] sum_comb;
  always_comb begin
    sum_comb = '0;
    for (int k = 0; k < 9; k++) sum_comb = sum_comb + ACC_W'(s1_prod[k]);
  end

  // Arithmetic shift floors toward -inf; magnitude is taken after the shift, clamp last.
  logic signed [ACC_W-1:0] shifted, mag;
  logic [DATA_W-1:0]       pix_out;
  always_comb begin
    shifted = s2_sum >>> s2_shift;
    mag     = (s2_abs && shifted[ACC_W-1]) ? -shifted : shifted;
    if (mag[ACC_W-1])      pix_out = '0;
    else if (mag > PIX_MAX) pix_out = '1;
    else                    pix_out = mag[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid               <= 1'b0;
      s2_valid               <= 1'b0;
      o_convolved_data_valid <= 1'b0;
      o_convolved_data       <= '0;
    end else if (en) begin
      s1_valid               <= i_pixel_data_valid;
      s2_valid               <= s1_valid;
      o_convolved_data_valid <= s2_valid;
      if (s2_valid) o_convolved_data <= pix_out;
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      s1_prod  <= mult;
      s1_shift <= i_shift;
      s1_abs   <= i_abs_mode;
      s2_sum   <= sum_comb;
      s2_shift <= s1_shift;
      s2_abs   <= s1_abs;
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: randomized and directed scoreboard bench for conv3x3_engine.
// Honours CONV3X3_COEF_WR_EN the same way as the design (kernel writes modelled only when defined).
module tb_conv3x3_engine;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [71:0] i_pixel_data;
  logic        i_pixel_data_valid;
  logic        o_in_ready;
  logic [3:0]  i_shift;
  logic        i_abs_mode;
  logic        i_coef_wr;
  logic [3:0]  i_coef_addr;
  logic [7:0]  i_coef_data;
  logic [7:0]  o_convolved_data;
  logic        o_convolved_data_valid;
  logic        i_out_ready;

  conv3x3_engine #(.DATA_W(8), .COEF_W(8), .SHIFT_W(4)) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_pixel_data           (i_pixel_data),
    .i_pixel_data_valid     (i_pixel_data_valid),
    .o_in_ready             (o_in_ready),
    .i_shift                (i_shift),
    .i_abs_mode             (i_abs_mode),
    .i_coef_wr              (i_coef_wr),
    .i_coef_addr            (i_coef_addr),
    .i_coef_data            (i_coef_data),
    .o_convolved_data       (o_convolved_data),
    .o_convolved_data_valid (o_convolved_data_valid),
    .i_out_ready            (i_out_ready)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int kern[9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void resetKernel();
    kern = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
  endfunction

  // Reference: integer dot product, floor division by 2^shift, optional magnitude, clamp to a byte.
  function automatic int refConv(input logic [71:0] pix, input int sh, input bit ab);
    int sum, d, q;
    sum = 0;
    for (int k = 0; k < 9; k++) sum += kern[k] * int'(pix[k*8 +: 8]);
    d = 1 << sh;
    if (sum >= 0) q = sum / d;
    else          q = -((-sum + d - 1) / d);
    if (ab && q < 0) q = -q;
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  function automatic logic [71:0] allPix(input int v);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [71:0] centrePix(input int c, input int others);
    logic [71:0] w;
    w = allPix(others);
    w[4*8 +: 8] = 8'(c);
    return w;
  endfunction

  function automatic logic [71:0] randPix();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // Drives one cycle; the model decides acceptance and kernel writes just before the edge.
  task automatic applyStimulus(input logic [71:0] pix, input bit pv, input int sh, input bit ab,
                               input bit wr, input int wa, input int wd, input bit rdy,
                               input bit rst_n, output bit accepted);
    i_pixel_data       = pix;
    i_pixel_data_valid = pv;
    i_shift            = 4'(sh);
    i_abs_mode         = ab;
    i_coef_wr          = wr;
    i_coef_addr        = 4'(wa);
    i_coef_data        = 8'(wd);
    i_out_ready        = rdy;
    i_rst_n            = rst_n;
    accepted           = 1'b0;
    @(negedge i_clk);
    if (!rst_n) begin
      exp_q.delete();
      resetKernel();
    end else begin
      if (pv && o_in_ready === 1'b1) begin
        exp_q.push_back(refConv(pix, sh, ab));
        accepted = 1'b1;
      end
`ifdef CONV3X3_COEF_WR_EN
      if (wr && wa <= 8) kern[wa] = int'($signed(8'(wd)));
`endif
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus('0, 0, 0, 0, 0, 0, 0, 1, 1, acc);
  endtask

  task automatic sendWindow(input logic [71:0] pix, input int sh, input bit ab);
    bit acc;
    applyStimulus(pix, 1, sh, ab, 0, 0, 0, 1, 1, acc);
    checkOutput("send_accept", int'(acc), 1);
  endtask

  task automatic writeCoef(input int wa, input int wd);
    bit acc;
    applyStimulus('0, 0, 0, 0, 1, wa, wd, 1, 1, acc);
  endtask

  // Counts rising edges, including the accepting one, until the result is valid.
  task automatic measureLatency(input string name, input logic [71:0] pix, input int sh, input bit ab);
    int edges;
    idleCycles(4);
    sendWindow(pix, sh, ab);
    i_pixel_data_valid = 1'b0;
    edges = 1;
    while (o_convolved_data_valid !== 1'b1 && edges < 10) begin
      @(posedge i_clk);
      #1;
      edges++;
    end
    checkOutput(name, edges, 3);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each transferred beat.
  initial begin
    bit         held;
    logic [7:0] held_data;
    int         e;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n !== 1'b1) begin
        held = 1'b0;
      end else begin
        checkOutput("in_ready", int'(o_in_ready),
                    int'(!o_convolved_data_valid || i_out_ready));
        if (o_convolved_data_valid === 1'b1) begin
          if (held) checkOutput("stall_hold", int'(o_convolved_data), int'(held_data));
          if (i_out_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_output", int'(o_convolved_data), -1);
            end else begin
              e = exp_q.pop_front();
              checkOutput("beat", int'(o_convolved_data), e);
            end
          end else begin
            held = 1'b1;
            held_data = o_convolved_data;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int got, cyc, sh;
    bit ab;
    logic [71:0] win;

    resetKernel();
    i_rst_n = 1'b0;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    i_shift = '0;
    i_abs_mode = 1'b0;
    i_coef_wr = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    i_out_ready = 1'b0;
    @(posedge i_clk);
    #1;
    applyStimulus('0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    checkOutput("reset_valid", int'(o_convolved_data_valid), 0);
    checkOutput("reset_data", int'(o_convolved_data), 0);
    checkOutput("reset_in_ready", int'(o_in_ready), 1);

    // Default Laplacian behaviour in clamp and abs modes.
    measureLatency("latency", allPix(100), 0, 0);
    sendWindow(centrePix(200, 100), 0, 0);
    sendWindow(centrePix(0, 50), 0, 0);
    sendWindow(centrePix(0, 50), 0, 1);
    idleCycles(5);

    // Gaussian kernel; address 12 must be ignored.
    for (int k = 0; k < 9; k++) writeCoef(k, (k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1));
    writeCoef(12, 99);
    win = '0;
    win[7:0] = 8'd16;
    sendWindow(allPix(255), 4, 0);
    sendWindow(win, 4, 0);
    applyStimulus(allPix(255), 1, 4, 0, 1, 4, 0, 1, 1, acc);
    checkOutput("write_edge_accept", int'(acc), 1);
    sendWindow(allPix(255), 4, 0);
    idleCycles(5);

    // Most-negative coefficient everywhere, deep shift, abs mode.
    for (int k = 0; k < 9; k++) writeCoef(k, -128);
    sendWindow(allPix(255), 15, 1);
    sendWindow(allPix(255), 15, 0);
    idleCycles(5);

    // Ten back-to-back windows with ready pattern 1,0,0.
    got = 0;
    cyc = 0;
    win = randPix();
    while (got < 10 && cyc < 200) begin
      applyStimulus(win, 1, cyc % 5, cyc[0], 0, 0, 0, (cyc % 3) == 0, 1, acc);
      if (acc) begin
        got++;
        win = randPix();
      end
      cyc++;
    end
    checkOutput("stream_count", got, 10);
    idleCycles(6);

    // Reset with three windows in flight; the window offered on the reset edge is dropped.
    for (int i = 0; i < 3; i++) sendWindow(randPix(), 2, 0);
    applyStimulus(allPix(77), 1, 0, 0, 1, 4, 9, 0, 0, acc);
    checkOutput("midreset_valid", int'(o_convolved_data_valid), 0);
    checkOutput("midreset_data", int'(o_convolved_data), 0);
    checkOutput("midreset_in_ready", int'(o_in_ready), 1);
    measureLatency("post_reset_latency", allPix(100), 0, 0);
    sendWindow(centrePix(200, 100), 0, 0);
    idleCycles(5);

    // Randomized traffic with writes, stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      sh = int'($urandom_range(0, 15));
      ab = 1'($urandom_range(0, 1));
      applyStimulus(randPix(), ($urandom_range(0, 3) != 0), sh, ab,
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 99) != 0), acc);
    end
    idleCycles(10);
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Parametrised 3x3 convolution stage for the video filter chain. It takes one packed 3x3 pixel window per beat from the line-buffer block and applies a runtime-loadable signed kernel with full-precision accumulation. The result is normalised by a programmable right shift, then clamped or absolute-valued back to pixel width. Unlike the fixed-kernel stages it replaces, it supports downstream backpressure through a three-stage valid/ready pipeline.

## Interface
- DATA_W, 8, pixel width (unsigned)
- COEF_W, 8, coefficient width (signed two's complement)
- SHIFT_W, 4, width of normalisation shift field
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_pixel_data  in  9*DATA_W  window, pixel k at [k*DATA_W +: DATA_W], k=0 top-left, row-major
- i_pixel_data_valid  in  1  window valid
- o_in_ready  out  1  engine accepts window this cycle
- i_shift  in  SHIFT_W  arithmetic right shift applied to sum, sampled with window
- i_abs_mode  in  1  1 = output |sum|, 0 = clamp signed sum; sampled with window
- i_coef_wr  in  1  coefficient write strobe
- i_coef_addr  in  4  coefficient index 0..8; 9..15 ignored
- i_coef_data  in  COEF_W  coefficient value
- o_convolved_data  out  DATA_W  result pixel
- o_convolved_data_valid  out  1  result valid
- i_out_ready  in  1  downstream accepts result

## Operation
- Kernel held in 9 COEF_W registers; reset value is Laplacian 0,-1,0,-1,4,-1,0,-1,0.
- Stage 1 (multiply): product k = signed coef k x zero-extended pixel k; width DATA_W+COEF_W+1. Captures i_shift, i_abs_mode.
- Stage 2 (sum): signed sum of 9 products, ACC_W = DATA_W+COEF_W+5, no overflow possible.
- Stage 3 (normalise): arithmetic shift right by captured shift (floor toward -inf). Abs mode: take magnitude. Then clamp to [0, 2^DATA_W-1]: negative -> 0, above max -> max.
- Global advance en = !o_convolved_data_valid || i_out_ragy; o_in_ready = en (combinational from i_out_ready and output valid).
- Window accepted when i_pixel_data_valid && o_in_ready. When en=0 all stages and valids hold, and output data is stable.
- Coefficient write: when i_coef_wr and addr<=8, coef[addr] <= i_coef_data at that edge. Windows accepted on the same edge use the old value; later windows use the new one. Windows in flight are unaffected. Writes are accepted regardless of en.
- Reset (i_rst_n=0 at edge): all stage valids 0, o_convolved_data 0, o_convolved_data_valid 0, kernel to default. This holds mid-stream; in-flight windows are discarded.

## Timing
- Latency 3 cycles from accepting edge to o_convolved_data_valid high, absent stalls.
- Throughput 1 window/cycle while i_out_ready=1.
- Stall: each cycle with en=0 adds exactly one cycle to every in-flight window; nothing is dropped or duplicated.
- Valid/data pair holds until the cycle i_out_ready=1.
- During reset o_in_ready = 1 (output valid is 0), but no window is accepted on a reset edge.

## Configuration
- CONV3X3_COEF_WR_EN defined: runtime coefficient write port is active as described.
- Not defined: i_coef_wr/i_coef_addr/i_coef_data are ignored. The kernel is a constant Laplacian, so coefficient registers are absent and synthesis may fold the multipliers. All other behaviour is identical.

## Test plan
- Default kernel, all pixels 100, shift 0, clamp mode: 3 cycles later output 0. Centre 200 with others 100, clamp mode: output 255 (sum 400 clamped).
- Centre 0 with others 50, clamp mode -> 0 (sum -200). Same window in abs mode -> 200.
- Write Gaussian 1,2,1,2,4,2,1,2,1, shift 4, all pixels 255: output 255. Pixel window 16,0,...,0 -> 1. Check that a window accepted on the write edge still uses the old kernel.
- Stream 10 windows back-to-back, i_out_ready toggling 1,0,0,1,...: outputs in order, none lost or duplicated, data stable while stalled, o_in_ready low whenever output valid and not ready.
- Assert i_rst_n low for 1 cycle with 3 windows in flight: valids clear next edge, output 0, kernel back to default, first post-reset window appears 3 cycles after acceptance.
- Coefficient -128 at every tap, all pixels 255, shift 15, abs mode: sum -293760 -> shifted -9 -> abs 9 (width/sign-extension check).
